// File: rtl/jk_counter_n.sv
// jk_counter_n: WIDTH-bit JK register with per-bit JK mode and modulo-MODULUS up/down counting.
// Define JK_COUNTER_SAT_EN to make up/down counting saturate at the limits instead of wrapping.
module jk_counter_n #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             preset,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qnot,
  output logic             tc
);

  if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_param_check
    $error("jk_counter_n: illegal parameters WIDTH=%0d MODULUS=%0d", WIDTH, MODULUS);
  end

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_JK   = 2'b11;

  localparam logic [WIDTH-1:0] TOP  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0] q_next;

  // Out-of-range values (only reachable through JK mode) snap back into the count range.
  function automatic logic [WIDTH-1:0] count_up(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v > TOP) begin
      r = ZERO;
    end else if (v == TOP) begin
`ifdef JK_COUNTER_SAT_EN
      r = TOP;
`else
      r = ZERO;
`endif
    end else begin
      r = v + WIDTH'(1);
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] count_down(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v > TOP) begin
      r = TOP;
    end else if (v == ZERO) begin
`ifdef JK_COUNTER_SAT_EN
      r = ZERO;
`else
      r = TOP;
`endif
    end else begin
      r = v - WIDTH'(1);
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] jk_update(input logic [WIDTH-1:0] v,
                                                 input logic [WIDTH-1:0] jv,
                                                 input logic [WIDTH-1:0] kv);
    return (jv & ~v) | (~kv & v);
  endfunction

  always_comb begin
    q_next = q;
    if (clr) begin
      q_next = ZERO;
    end else if (en) begin
      case (mode)
        MODE_HOLD: q_next = q;
        MODE_UP:   q_next = count_up(q);
        MODE_DOWN: q_next = count_down(q);
        MODE_JK:   q_next = jk_update(q, j, k);
        default:   q_next = q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      q <= TOP;
    end else begin
      q <= q_next;
    end
  end

  assign qnot = ~q;

  // tc anticipates the wrap/limit so a higher-order stage can use it as its enable.
  always_comb begin
    tc = 1'b0;
    if (en && !clr && !preset) begin
      tc = ((mode == MODE_UP) && (q == TOP)) || ((mode == MODE_DOWN) && (q == ZERO));
    end
  end

endmodule

// File: tb/tb_jk_counter_n.sv
// Bench for jk_counter_n: a WIDTH=4/MODULUS=10 instance and a WIDTH=3/MODULUS=8 instance share stimulus.
module tb_jk_counter_n;

`ifdef JK_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       preset = 1'b0;
  logic       clr = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] j4 = '0, k4 = '0, q4, qn4;
  logic [2:0] j8 = '0, k8 = '0, q8, qn8;
  logic       tc4, tc8;

  int total = 0;
  int bad = 0;
  int mq4, mq8;
  logic tc4s, tc8s;

  jk_counter_n #(.WIDTH(4), .MODULUS(10)) u_m10 (
    .clk(clk), .preset(preset), .clr(clr), .en(en), .mode(mode),
    .j(j4), .k(k4), .q(q4), .qnot(qn4), .tc(tc4)
  );

  jk_counter_n #(.WIDTH(3), .MODULUS(8)) u_m8 (
    .clk(clk), .preset(preset), .clr(clr), .en(en), .mode(mode),
    .j(j8), .k(k8), .q(q8), .qnot(qn8), .tc(tc8)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         c;
    bit         e;
    logic [1:0] md;
    logic [3:0] jj;
    logic [3:0] kk;
    int         eq;
    bit         etc;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input bit c, input bit e, input logic [1:0] md,
                              input logic [3:0] jj, input logic [3:0] kk,
                              input int eq, input bit etc);
    vec_t v;
    v.c = c; v.e = e; v.md = md; v.jj = jj; v.kk = kk; v.eq = eq; v.etc = etc;
    vt.push_back(v);
  endfunction

  // Reference model: integer arithmetic straight from the counting rules.
  function automatic int model_next(input int qv, input int w, input int m, input bit c,
                                    input bit e, input logic [1:0] md, input int jv, input int kv);
    int r;
    if (c) return 0;
    if (!e) return qv;
    case (md)
      2'd0: r = qv;
      2'd1: begin
        if (qv >= m) r = 0;
        else if (qv == m - 1) r = SAT ? m - 1 : 0;
        else r = qv + 1;
      end
      2'd2: begin
        if (qv >= m) r = m - 1;
        else if (qv == 0) r = SAT ? 0 : m - 1;
        else r = qv - 1;
      end
      default: begin
        r = 0;
        for (int i = 0; i < w; i++) begin
          int qb, jb, kb, nb;
          qb = (qv >> i) & 1;
          jb = (jv >> i) & 1;
          kb = (kv >> i) & 1;
          if (jb == 1 && kb == 1) nb = 1 - qb;
          else if (jb == 1) nb = 1;
          else if (kb == 1) nb = 0;
          else nb = qb;
          r = r | (nb << i);
        end
      end
    endcase
    return r;
  endfunction

  function automatic bit model_tc(input int qv, input int m, input bit p, input bit c,
                                  input bit e, input logic [1:0] md);
    return e && !c && !p && ((md == 2'd1 && qv == m - 1) || (md == 2'd2 && qv == 0));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clocked operation: drive, check tc before the edge, clock, check state after.
  task automatic step(input bit c, input bit e, input logic [1:0] md,
                      input logic [3:0] jj, input logic [3:0] kk);
    clr = c; en = e; mode = md; j4 = jj; k4 = kk; j8 = jj[2:0]; k8 = kk[2:0];
    #1;
    tc4s = tc4;
    tc8s = tc8;
    chk("tc_m10", tc4, model_tc(mq4, 10, preset, c, e, md));
    chk("tc_m8", tc8, model_tc(mq8, 8, preset, c, e, md));
    @(posedge clk);
    mq4 = model_next(mq4, 4, 10, c, e, md, jj, kk);
    mq8 = model_next(mq8, 3, 8, c, e, md, jj & 7, kk & 7);
    @(negedge clk);
    #1;
    chk("q_m10", q4, mq4);
    chk("qnot_m10", qn4, (~mq4) & 15);
    chk("q_m8", q8, mq8);
    chk("qnot_m8", qn8, (~mq8) & 7);
  endtask

  task automatic preset_pulse();
    preset = 1'b1;
    #1;
    chk("preset_q_m10", q4, 9);
    chk("preset_qnot_m10", qn4, 6);
    chk("preset_q_m8", q8, 7);
    chk("preset_tc_m10", tc4, 0);
    chk("preset_tc_m8", tc8, 0);
    #1;
    preset = 1'b0;
    mq4 = 9;
    mq8 = 7;
  endtask

  initial begin
    // Directed table, starting from q=0 on the MODULUS=10 instance.
    for (int i = 1; i <= 10; i++) add(0, 1, 2'd1, 0, 0, (i < 10) ? i : (SAT ? 9 : 0), i == 10);
    add(1, 0, 2'd1, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) add(0, 1, 2'd2, 0, 0, SAT ? 0 : 10 - i, SAT ? 1 : (i == 1));
    for (int i = 0; i < 3; i++) add(0, 0, 2'd2, 0, 0, SAT ? 0 : 7, 0);
    add(1, 1, 2'd3, 4'hF, 4'hF, 0, 0);
    add(0, 1, 2'd3, 4'b0101, 4'b0000, 5, 0);
    add(0, 1, 2'd3, 4'b1010, 4'b0101, 10, 0);
    add(0, 1, 2'd1, 0, 0, 0, 0);
    add(0, 1, 2'd3, 4'b0101, 4'b1010, 5, 0);
    add(0, 1, 2'd3, 4'b1010, 4'b0101, 10, 0);
    add(0, 1, 2'd2, 0, 0, 9, 0);
    add(0, 1, 2'd3, 4'b1111, 4'b1111, 6, 0);
    add(0, 1, 2'd3, 4'b0000, 4'b0000, 6, 0);
    add(0, 1, 2'd0, 0, 0, 6, 0);
    add(0, 1, 2'd3, 4'b1001, 4'b0000, 15, 0);
    add(0, 1, 2'd1, 0, 0, 0, 0);
    add(0, 1, 2'd2, 0, 0, SAT ? 0 : 9, 1);
    add(1, 0, 2'd0, 0, 0, 0, 0);

    // Asynchronous preset between edges, before any clock edge has occurred.
    #2;
    preset_pulse();
    @(negedge clk);
    #1;
    step(1, 0, 2'd0, 0, 0);
    chk("clr_after_preset", q4, 0);

    foreach (vt[i]) begin
      step(vt[i].c, vt[i].e, vt[i].md, vt[i].jj, vt[i].kk);
      chk($sformatf("vec%0d_q", i), q4, vt[i].eq);
      chk($sformatf("vec%0d_tc", i), tc4s, vt[i].etc);
    end

    // Preset 2 ns after an edge while counting, then preset+clr, then release under clr.
    for (int i = 0; i < 3; i++) step(0, 1, 2'd1, 0, 0);
    chk("count_before_preset", q4, 3);
    @(posedge clk);
    #2;
    preset = 1'b1;
    #1;
    chk("midcount_preset_q", q4, 9);
    chk("midcount_preset_qnot", qn4, 6);
    chk("midcount_preset_tc", tc4, 0);
    clr = 1'b1;
    @(posedge clk);
    #1;
    chk("preset_beats_clr", q4, 9);
    @(negedge clk);
    preset = 1'b0;
    mq4 = 9;
    mq8 = 7;
    step(1, 1, 2'd1, 0, 0);
    chk("release_with_clr", q4, 0);
    preset_pulse();
    step(0, 1, 2'd1, 0, 0);
    chk("resume_from_top", q4, SAT ? 9 : 0);

    // Natural-overflow instance: tc at 7, then 7 -> 0 (or hold when saturating).
    preset_pulse();
    step(0, 1, 2'd1, 0, 0);
    chk("m8_tc_at_7", tc8s, 1);
    chk("m8_wrap", q8, SAT ? 7 : 0);

    // Randomised traffic against the model, with occasional asynchronous presets.
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 31) == 0) preset_pulse();
      step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
